instr_fetch_buffer: RTL and testbench

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

---
 rtl/instr_fetch_buffer.sv | 137 +++++++++++++
 tb/tb_instr_fetch_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: circular FIFO between the fetch and decode stages.
// Optional decode-stall performance counter enabled by defining IFB_PERF_CNT_EN.
module instr_fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid_i,
  input  logic [31:0]              if_instr_i,
  input  logic [31:0]              if_pc_i,
  output logic                     if_ready_o,
  input  logic                     flush_i,
  input  logic                     id_stall_i,
  output logic                     id_valid_o,
  output logic [31:0]              id_instr_o,
  output logic [31:0]              id_pc_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [31:0]              stall_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [31:0]   instr_mem_r [DEPTH];
  logic [31:0]   pc_mem_r    [DEPTH];

  logic          ready_s;
  logic          valid_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   head_instr_s;
  logic [31:0]   head_pc_s;

  // Handshake decode; flush suppresses both push and pop.
  always_comb begin
    ready_s = 1'b0;
    valid_s = 1'b0;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    if (count_r < DEPTH_C) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
    if (count_r != CNT_ZERO) begin
      valid_s = 1'b1;
    end else begin
      valid_s = 1'b0;
    end
    if (flush_i) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
      push_s = if_valid_i & ready_s;
      pop_s  = valid_s & ~id_stall_i;
    end
  end

  // Pointer and occupancy state; flush takes priority over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (flush_i) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array: written only on a push, never reset, never touched by a pop.
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_mem_r[wr_ptr_r] <= if_instr_i;
      pc_mem_r[wr_ptr_r]    <= if_pc_i;
    end
  end

  // Head selection; an empty buffer presents a NOP at PC 0 so array contents never leak.
  always_comb begin
    head_instr_s = 32'h0000_0000;
    head_pc_s    = 32'h0000_0000;
    if (valid_s) begin
      head_instr_s = instr_mem_r[rd_ptr_r];
      head_pc_s    = pc_mem_r[rd_ptr_r];
    end else begin
      head_instr_s = 32'h0000_0000;
      head_pc_s    = 32'h0000_0000;
    end
  end

  assign if_ready_o = ready_s;
  assign id_valid_o = valid_s;
  assign id_instr_o = head_instr_s;
  assign id_pc_o    = head_pc_s;
  assign count_o    = count_r;

`ifdef IFB_PERF_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles where decode holds a valid head; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 32'h0000_0000;
    end else if (valid_s && id_stall_i && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`else
  assign stall_cnt_o = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Scoreboard bench for instr_fetch_buffer: stimulus queues expected words,
// a negedge monitor checks every word the decode stage consumes.
module tb_instr_fetch_buffer;

  logic        clk;
  logic        rst;
  logic        if_valid_i;
  logic [31:0] if_instr_i;
  logic [31:0] if_pc_i;
  logic        if_ready_o;
  logic        flush_i;
  logic        id_stall_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [2:0]  count_o;
  logic [31:0] stall_cnt_o;

  int          checks;
  int          failures;
  logic [63:0] exp_q [$];
  int          m_count;
  logic [31:0] m_stall;
  logic [31:0] s0;
  logic [31:0] exp_delta;

  instr_fetch_buffer #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid_i  (if_valid_i),
    .if_instr_i  (if_instr_i),
    .if_pc_i     (if_pc_i),
    .if_ready_o  (if_ready_o),
    .flush_i     (flush_i),
    .id_stall_i  (id_stall_i),
    .id_valid_o  (id_valid_o),
    .id_instr_o  (id_instr_o),
    .id_pc_o     (id_pc_o),
    .count_o     (count_o),
    .stall_cnt_o (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the reference queue is updated after the edge.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic st, input logic fl);
    logic m_push;
    logic m_pop;
    if_valid_i = v;
    if_instr_i = ins;
    if_pc_i    = pc;
    id_stall_i = st;
    flush_i    = fl;
    m_push = v && (m_count < 4) && !fl;
    m_pop  = (m_count != 0) && !st && !fl;
`ifdef IFB_PERF_CNT_EN
    if ((m_count != 0) && st && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
`endif
    @(posedge clk);
    #1;
    if (fl) begin
      m_count = 0;
      exp_q.delete();
    end else begin
      if (m_push) exp_q.push_back({ins, pc});
      m_count = m_count + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
    end
  endtask

  // Monitor: each cycle the decode stage consumes the head, compare it with the queue front.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      if (id_valid_o) begin
        if (!id_stall_i && !flush_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pop actual=%h expected=none t=%0t", id_instr_o, $time);
          end else begin
            e = exp_q.pop_front();
            chk("pop_instr", id_instr_o, e[63:32]);
            chk("pop_pc", id_pc_o, e[31:0]);
          end
        end
      end else begin
        chk("idle_instr", id_instr_o, 32'h0000_0000);
        chk("idle_pc", id_pc_o, 32'h0000_0000);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; failures = 0; m_count = 0; m_stall = 32'd0;
    rst = 1'b1; if_valid_i = 1'b0; if_instr_i = 32'd0; if_pc_i = 32'd0;
    flush_i = 1'b0; id_stall_i = 1'b0;
    #2;
    chk("rst_valid", {31'd0, id_valid_o}, 32'd0);
    chk("rst_instr", id_instr_o, 32'd0);
    chk("rst_pc", id_pc_o, 32'd0);
    chk("rst_ready", {31'd0, if_ready_o}, 32'd1);
    chk("rst_count", {29'd0, count_o}, 32'd0);
    chk("rst_stall_cnt", stall_cnt_o, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Fill under stall: head stays on the first word.
    for (int n = 0; n < 4; n++) begin
      cyc(1'b1, 32'h2402_0001 + n, 32'hBFC0_0000 + 32'(4 * n), 1'b1, 1'b0);
      chk("fill_head_stable", id_instr_o, 32'h2402_0001);
    end
    chk("fill_count", {29'd0, count_o}, 32'd4);
    chk("fill_ready", {31'd0, if_ready_o}, 32'd0);
    cyc(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
    chk("full_reject_count", {29'd0, count_o}, 32'd4);
    chk("full_head_stable", id_instr_o, 32'h2402_0001);
    chk("full_pc_stable", id_pc_o, 32'hBFC0_0000);
    chk("stall_cnt_fill", stall_cnt_o, m_stall);

    // Drain in push order.
    for (int n = 0; n < 4; n++) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("drain_valid", {31'd0, id_valid_o}, 32'd0);
    chk("drain_instr", id_instr_o, 32'd0);
    chk("drain_count", {29'd0, count_o}, 32'd0);

    // Two entries, then ten cycles of simultaneous push and pop across the wrap.
    cyc(1'b1, 32'h1000_0000, 32'h0000_0100, 1'b1, 1'b0);
    cyc(1'b1, 32'h1000_0001, 32'h0000_0104, 1'b1, 1'b0);
    chk("pp_start_count", {29'd0, count_o}, 32'd2);
    for (int n = 2; n < 12; n++) begin
      cyc(1'b1, 32'h1000_0000 + n, 32'h0000_0100 + 32'(4 * n), 1'b0, 1'b0);
      chk("pp_count", {29'd0, count_o}, 32'd2);
    end

    // Flush with a concurrent push: everything dropped.
    cyc(1'b1, 32'h1000_000C, 32'h0000_0130, 1'b1, 1'b0);
    chk("pre_flush_count", {29'd0, count_o}, 32'd3);
    cyc(1'b1, 32'hBAD0_BAD0, 32'h0000_0BAD, 1'b0, 1'b1);
    chk("flush_count", {29'd0, count_o}, 32'd0);
    chk("flush_valid", {31'd0, id_valid_o}, 32'd0);
    chk("flush_instr", id_instr_o, 32'd0);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("flush_dropped_valid", {31'd0, id_valid_o}, 32'd0);

    // Performance counter: one entry held for five stalled cycles.
    cyc(1'b1, 32'h2000_0001, 32'h0000_0200, 1'b1, 1'b0);
    s0 = stall_cnt_o;
    for (int n = 0; n < 5; n++) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
`ifdef IFB_PERF_CNT_EN
    exp_delta = 32'd5;
`else
    exp_delta = 32'd0;
`endif
    chk("perf_delta", stall_cnt_o - s0, exp_delta);
    chk("perf_total", stall_cnt_o, m_stall);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Asynchronous reset between edges with two entries buffered.
    cyc(1'b1, 32'h3000_0001, 32'h0000_0300, 1'b1, 1'b0);
    cyc(1'b1, 32'h3000_0002, 32'h0000_0304, 1'b1, 1'b0);
    chk("pre_rst_count", {29'd0, count_o}, 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, id_valid_o}, 32'd0);
    chk("arst_count", {29'd0, count_o}, 32'd0);
    chk("arst_instr", id_instr_o, 32'd0);
    chk("arst_ready", {31'd0, if_ready_o}, 32'd1);
    chk("arst_stall_cnt", stall_cnt_o, 32'd0);
    exp_q.delete();
    m_count = 0;
    m_stall = 32'd0;
    if_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Post-reset traffic still flows in order.
    cyc(1'b1, 32'h4000_0001, 32'h0000_0400, 1'b0, 1'b0);
    cyc(1'b1, 32'h4000_0002, 32'h0000_0404, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("end_count", {29'd0, count_o}, 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
